// File: rtl/whack_score_ctrl.sv
// Whac-A-Mole round controller: qualifies hole hits against the moles that are up,
// round-robin scores one hit per cycle, tracks difficulty level and the round countdown.
module whack_score_ctrl #(
    parameter int N_HOLES    = 4,
    parameter int SCORE_W    = 6,
    parameter int TICK_DIV   = 50000000,
    parameter int ROUND_SEC  = 30,
    parameter int LEVEL_STEP = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_HOLES-1:0] hit,
    input  logic [N_HOLES-1:0] mole_mask,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         level,
    output logic [5:0]         time_left,
    output logic [N_HOLES-1:0] hit_ack,
    output logic               level_up,
    output logic               playing,
    output logic               game_over
);
    localparam int PW = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(LEVEL_STEP + 5) + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t             state;
    logic [N_HOLES-1:0] pending;
    logic [PW-1:0]      rr;
    logic [TW-1:0]      tick;
    logic [AW-1:0]      acc;

    logic [N_HOLES-1:0] qual, gnt_oh;
    logic [PW-1:0]      gnt_idx, sel_b, rr_nxt;
    logic               gnt_any;
    int                 sel;

    // first pending hole at or after the round-robin pointer, wrapping
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sel     = 0;
        sel_b   = '0;
        for (int k = 0; k < N_HOLES; k++) begin
            sel = int'(rr) + k;
            if (sel >= N_HOLES) sel = sel - N_HOLES;
            sel_b = PW'(sel);
            if (!gnt_any && pending[sel_b]) begin
                gnt_any        = 1'b1;
                gnt_idx        = sel_b;
                gnt_oh[sel_b]  = 1'b1;
            end
        end
    end

    assign qual   = hit & mole_mask;
    assign rr_nxt = (int'(gnt_idx) == N_HOLES - 1) ? '0 : gnt_idx + 1'b1;

    logic [2:0]         weight;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_nxt;
    logic [AW-1:0]      acc_sum;
    logic               lvl_wrap, tick_last;

    // weight never exceeds 4, so any overflow past SCORE_MAX shows up in the carry bit
    assign weight    = {1'b0, level} + 3'd1;
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(weight);
    assign score_nxt = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
    assign acc_sum   = acc + AW'(weight);
    assign lvl_wrap  = (acc_sum >= AW'(LEVEL_STEP));
    assign tick_last = (tick == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            score     <= '0;
            level     <= '0;
            time_left <= 6'(ROUND_SEC);
            hit_ack   <= '0;
            level_up  <= 1'b0;
            playing   <= 1'b0;
            game_over <= 1'b0;
            pending   <= '0;
            rr        <= '0;
            tick      <= '0;
            acc       <= '0;
        end else begin
            hit_ack  <= '0;
            level_up <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= PLAY;
                        score     <= '0;
                        level     <= '0;
                        acc       <= '0;
                        time_left <= 6'(ROUND_SEC);
                        tick      <= '0;
                        pending   <= '0;
                        rr        <= '0;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                PLAY: begin
                    // a fresh qualified hit on the granted hole keeps it pending
                    pending <= (pending & ~gnt_oh) | qual;
                    if (gnt_any) begin
                        score   <= score_nxt;
                        rr      <= rr_nxt;
                        hit_ack <= gnt_oh;
                        if (lvl_wrap) begin
                            acc <= acc_sum - AW'(LEVEL_STEP);
                            if (level != 2'd3) begin
                                level    <= level + 2'd1;
                                level_up <= 1'b1;
                            end
                        end else begin
                            acc <= acc_sum;
                        end
                    end
                    if (tick_last) begin
                        tick <= '0;
                        if (time_left <= 6'd1) begin
                            state     <= OVER;
                            time_left <= '0;
                            pending   <= '0;
                            hit_ack   <= '0;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            time_left <= time_left - 6'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_whack_score_ctrl.sv
// Bench for whack_score_ctrl: directed rounds plus random play, checked against a reference model.
module tb_whack_score_ctrl;
    localparam int NH = 4;
    localparam int SW = 4;
    localparam int TD = 4;
    localparam int RS = 3;
    localparam int LS = 4;
    localparam int SMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NH-1:0] hit = '0;
    logic [NH-1:0] mole_mask = '0;
    logic [SW-1:0] score;
    logic [1:0]    level;
    logic [5:0]    time_left;
    logic [NH-1:0] hit_ack;
    logic          level_up, playing, game_over;

    whack_score_ctrl #(.N_HOLES(NH), .SCORE_W(SW), .TICK_DIV(TD), .ROUND_SEC(RS), .LEVEL_STEP(LS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .mole_mask(mole_mask),
        .score(score), .level(level), .time_left(time_left), .hit_ack(hit_ack),
        .level_up(level_up), .playing(playing), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [SW-1:0] score;
        logic [1:0]    level;
        logic [5:0]    tl;
        logic [NH-1:0] ack;
        logic          lu;
        logic          pl;
        logic          ov;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    // reference model: game phase 0=waiting, 1=in a round, 2=round finished
    int m_phase, m_pend, m_rr, m_score, m_level, m_acc, m_tl, m_tick, m_ack, m_lu;

    task automatic model_reset();
        m_phase = 0; m_pend = 0; m_rr = 0; m_score = 0; m_level = 0;
        m_acc = 0; m_tl = RS; m_tick = 0; m_ack = 0; m_lu = 0;
    endtask

    task automatic model_step(input bit s, input int h, input int m);
        int g;
        int w;
        m_ack = 0;
        m_lu  = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_phase != 1) begin
            if (s) begin
                m_phase = 1; m_score = 0; m_level = 0; m_acc = 0;
                m_tl = RS; m_tick = 0; m_pend = 0; m_rr = 0;
            end
            return;
        end
        g = -1;
        for (int k = 0; k < NH; k++)
            if (g < 0 && ((m_pend >> ((m_rr + k) % NH)) & 1) == 1) g = (m_rr + k) % NH;
        if (g >= 0) begin
            w = m_level + 1;
            m_score = (m_score + w > SMAX) ? SMAX : m_score + w;
            m_acc = m_acc + w;
            if (m_acc >= LS) begin
                m_acc = m_acc - LS;
                if (m_level < 3) begin
                    m_level++;
                    m_lu = 1;
                end
            end
            m_pend = m_pend & ~(1 << g);
            m_rr = (g + 1) % NH;
            m_ack = 1 << g;
        end
        m_pend = m_pend | (h & m);
        m_tick++;
        if (m_tick == TD) begin
            m_tick = 0;
            m_tl--;
            if (m_tl == 0) begin
                m_phase = 2;
                m_pend = 0;
                m_ack = 0;
            end
        end
    endtask

    task automatic push_exp();
        exp_t x;
        x.score = SW'(m_score);
        x.level = 2'(m_level);
        x.tl    = 6'(m_tl);
        x.ack   = NH'(m_ack);
        x.lu    = 1'(m_lu);
        x.pl    = (m_phase == 1);
        x.ov    = (m_phase == 2);
        exp_q.push_back(x);
    endtask

    task automatic step(input logic s, input logic [NH-1:0] h, input logic [NH-1:0] m);
        start = s;
        hit = h;
        mole_mask = m;
        @(posedge clk);
        model_step(s, int'(h), int'(m));
        push_exp();
        @(negedge clk);
        start = 1'b0;
        hit = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_time_left"}, int'(time_left), RS);
        chk({tag, "_hit_ack"}, int'(hit_ack), 0);
        chk({tag, "_level_up"}, int'(level_up), 0);
        chk({tag, "_playing"}, int'(playing), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
    endtask

    // monitor: every output cycle is compared with what the model predicted for it
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_outputs", int'({score, level, time_left, hit_ack, level_up, playing, game_over}), int'(e));
        end
    end

    int exp_sc[11] = '{1, 2, 3, 4, 6, 8, 11, 14, 15, 15, 15};
    int exp_lv[11] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
    int exp_lu[11] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    int exp_ak[11] = '{1, 2, 4, 8, 1, 2, 4, 8, 1, 2, 0};

    initial begin
        model_reset();
        step(0, '0, '0);
        step(0, '0, '0);
        rst_n = 1'b1;
        chk_reset_vals("reset");

        // countdown, and hits ignored outside a round
        step(0, 4'hF, 4'hF);
        step(1, '0, '0);
        chk("start_playing", int'(playing), 1);
        chk("start_time_left", int'(time_left), 3);
        repeat (4) step(0, '0, '0);
        chk("time_left_after_4", int'(time_left), 2);
        repeat (8) step(0, '0, '0);
        chk("over_game_over", int'(game_over), 1);
        chk("over_time_left", int'(time_left), 0);
        chk("over_playing", int'(playing), 0);
        step(0, 4'hF, 4'hF);
        step(0, '0, '0);
        chk("over_hit_ignored", int'(hit_ack), 0);

        // arbitration order, mole-down discard, level weight
        step(1, '0, '0);
        chk("restart_game_over", int'(game_over), 0);
        step(0, 4'b0101, 4'hF);
        step(0, '0, '0);
        chk("rr_first_ack", int'(hit_ack), 1);
        chk("rr_first_score", int'(score), 1);
        step(0, '0, '0);
        chk("rr_second_ack", int'(hit_ack), 4);
        chk("rr_second_score", int'(score), 2);
        step(0, 4'b0101, 4'hF);
        step(0, '0, '0);
        chk("rr_wrap_ack", int'(hit_ack), 1);
        step(0, '0, '0);
        chk("lvl1_score", int'(score), 4);
        chk("lvl1_level", int'(level), 1);
        chk("lvl1_level_up", int'(level_up), 1);
        step(0, 4'b0010, 4'b1101);
        step(0, '0, '0);
        chk("mole_down_ack", int'(hit_ack), 0);
        chk("mole_down_score", int'(score), 4);
        step(0, 4'b0001, 4'hF);
        step(0, '0, '0);
        chk("weight2_score", int'(score), 6);
        step(0, '0, '0);
        step(0, '0, '0);
        chk("round2_over", int'(game_over), 1);

        // continuous hits: level 3 and saturation
        step(1, '0, '0);
        step(0, 4'hF, 4'hF);
        for (int i = 0; i < 11; i++) begin
            step(0, 4'hF, 4'hF);
            chk($sformatf("burst%0d_score", i), int'(score), exp_sc[i]);
            chk($sformatf("burst%0d_level", i), int'(level), exp_lv[i]);
            chk($sformatf("burst%0d_level_up", i), int'(level_up), exp_lu[i]);
            chk($sformatf("burst%0d_ack", i), int'(hit_ack), exp_ak[i]);
        end
        chk("burst_over", int'(game_over), 1);

        // asynchronous reset mid-round with hits pending
        step(1, '0, '0);
        step(0, 4'hF, 4'hF);
        step(0, '0, '0);
        chk("pre_reset_score", int'(score), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        model_reset();
        step(0, '0, '0);
        step(0, '0, '0);
        rst_n = 1'b1;
        step(0, '0, '0);
        step(1, '0, '0);
        chk("fresh_playing", int'(playing), 1);
        chk("fresh_score", int'(score), 0);
        repeat (3) step(0, '0, '0);
        chk("fresh_no_stale_ack", int'(hit_ack), 0);

        // random play
        for (int i = 0; i < 800; i++)
            step(($urandom_range(0, 7) == 0), NH'($urandom), NH'($urandom));

        step(0, '0, '0);
        #1 chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
